// File: rtl/mod_updown_counter.sv
// mod_updown_counter
// Synchronous up/down counter with a programmable modulus. The count runs
// 0..MODULUS-1 and wraps in both directions.
//
// Features:
//   - parallel load
//   - preset to the top value
//   - combinational terminal count (tc) for cascading stages
//   - registered one-cycle wrap and load_err pulses
//
// All state changes on the same clk edge, so there is no ripple glitching.
//
// Parameter constraints (not checked in hardware):
//   - 2 <= MODULUS <= 2**WIDTH
//   - RESET_VALUE < MODULUS

module mod_updown_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 16,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             clear,       // asynchronous, active-low reset
  input  logic             enable,
  input  logic             up_down,     // 1 = up, 0 = down
  input  logic             preset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Arithmetic is done one bit wider than the count. This keeps the
  // top-of-range compare valid when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q,    count_d;
  logic             wrap_q,     wrap_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;
  logic           at_top;
  logic           at_bottom;
  logic           load_ok;

  // Widened step values and the boundary and range decodes derived from them.
  always_comb begin
    inc_sum   = {1'b0, count_q} + ONE_EXT;
    dec_diff  = {1'b0, count_q} - ONE_EXT;
    at_top    = (inc_sum == MOD_EXT);         // count == MODULUS-1
    at_bottom = dec_diff[WIDTH];              // borrow out means count == 0
    load_ok   = ({1'b0, load_value} < MOD_EXT);
  end

  // Next-state selection: preset > load > enabled step > hold.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (preset) begin
      count_d = TOP;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_value;
      end else begin
        count_d    = TOP;
        load_err_d = 1'b1;
      end
    end else if (enable) begin
      if (up_down) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_sum[WIDTH-1:0];
        end
      end else begin
        if (at_bottom) begin
          count_d = TOP;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_diff[WIDTH-1:0];
        end
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge clear) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!clear) begin
      count_q    <= RST_VAL;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // tc depends only on enable, direction and count. It ignores load and
  // preset, so it can drive the next cascaded stage's enable.
  always_comb begin
    tc = enable & ((up_down & at_top) | (~up_down & at_bottom));
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter (WIDTH=4, MODULUS=10).
// Expected results are pushed to a scoreboard queue as stimulus is driven,
// then popped and compared after the clock edge.
`timescale 1ns/1ps

module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         enable = 1'b0;
  logic         up_down = 1'b1;
  logic         preset = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count;
  logic         tc, wrap, load_err;

  // Cascade pair: the high digit is enabled by the low digit's tc.
  logic         casc_en = 1'b0;
  logic [W-1:0] lo_count, hi_count;
  logic         lo_tc, lo_wrap, lo_load_err;
  logic         hi_tc, hi_wrap, hi_load_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         load_err;
    string        tag;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         hi_wrap;
  } casc_exp_t;

  casc_exp_t casc_q[$];

  // Reference model state.
  int m_count = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VALUE(0)) dut (
    .clk(clk), .clear(clear), .enable(enable), .up_down(up_down),
    .preset(preset), .load(load), .load_value(load_value),
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VALUE(0)) u_lo (
    .clk(clk), .clear(clear), .enable(casc_en), .up_down(1'b1),
    .preset(1'b0), .load(1'b0), .load_value(4'd0),
    .count(lo_count), .tc(lo_tc), .wrap(lo_wrap), .load_err(lo_load_err)
  );

  mod_updown_counter #(.WIDTH(W), .MODULUS(M), .RESET_VALUE(0)) u_hi (
    .clk(clk), .clear(clear), .enable(lo_tc), .up_down(1'b1),
    .preset(1'b0), .load(1'b0), .load_value(4'd0),
    .count(hi_count), .tc(hi_tc), .wrap(hi_wrap), .load_err(hi_load_err)
  );

  // Drive one cycle of stimulus, check tc, push the model's expectation,
  // then pop and compare it after the edge.
  task automatic step(input logic en, input logic ud, input logic pre,
                      input logic ld, input logic [W-1:0] lv, input string tag);
    exp_t e, a;
    logic exp_tc;
    @(negedge clk);
    enable = en; up_down = ud; preset = pre; load = ld; load_value = lv;
    #1;
    exp_tc = en & ((ud & (m_count == M-1)) | (!ud & (m_count == 0)));
    checks++;
    if (tc !== exp_tc) begin
      failures++;
      $display("FAIL %s_tc: tc=%b expected=%b (count=%0d)", tag, tc, exp_tc, m_count);
    end
    e.wrap = 1'b0; e.load_err = 1'b0; e.tag = tag;
    if (pre) begin
      m_count = M-1;
    end else if (ld) begin
      if (int'(lv) < M) m_count = int'(lv);
      else begin m_count = M-1; e.load_err = 1'b1; end
    end else if (en && ud) begin
      if (m_count == M-1) begin m_count = 0; e.wrap = 1'b1; end
      else m_count = m_count + 1;
    end else if (en && !ud) begin
      if (m_count == 0) begin m_count = M-1; e.wrap = 1'b1; end
      else m_count = m_count - 1;
    end
    e.count = W'(m_count);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s_sb: scoreboard empty", tag);
    end else begin
      a = sb_q.pop_front();
      if (count !== a.count || wrap !== a.wrap || load_err !== a.load_err) begin
        failures++;
        $display("FAIL %s: count=%0d wrap=%b load_err=%b expected count=%0d wrap=%b load_err=%b",
                 a.tag, count, wrap, load_err, a.count, a.wrap, a.load_err);
      end
    end
  endtask

  // Drop clear between edges and check the immediate effect.
  // Clear is held across one posedge, then released off the clock edge.
  task automatic async_clear(input string tag);
    @(negedge clk);
    #2 clear = 1'b0;
    #1;
    checks++;
    if (count !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_async: count=%0d wrap=%b load_err=%b expected 0/0/0",
               tag, count, wrap, load_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (count !== '0) begin
      failures++;
      $display("FAIL %s_held: count=%0d expected=0 while clear low", tag, count);
    end
    #2 clear = 1'b1;
    m_count = 0;
  endtask

  task automatic test_reset();
    #3 clear = 1'b0;
    #1;
    checks++;
    if (count !== '0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: count=%0d wrap=%b load_err=%b expected 0/0/0", count, wrap, load_err);
    end
    @(posedge clk);
    #3 clear = 1'b1;
    m_count = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, "hold");
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0, "up");
  endtask

  task automatic test_down_wrap();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, "down_load2");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, "down");
  endtask

  task automatic test_load_preset();
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd7,  "load7");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd12, "load12_err");
    step(1'b0, 1'b1, 1'b0, 1'b0, '0,    "err_clears");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, "load15_err");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  "preset_over_load");
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'd4,  "load_over_enable");
    step(1'b1, 1'b0, 1'b1, 1'b0, '0,    "preset_over_enable");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,    "dir_change_up");
    step(1'b1, 1'b0, 1'b0, 1'b0, '0,    "dir_change_down");
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, "mid_load5");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,   "mid_up6");
    async_clear("mid_at6");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,   "resume1");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,   "resume2");
    // Put wrap high, then confirm clear drops it without a clock.
    step(1'b0, 1'b1, 1'b1, 1'b0, '0,   "mid_preset");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,   "mid_wrap");
    async_clear("wrap_clear");
    step(1'b1, 1'b1, 1'b0, 1'b0, '0,   "resume_after_wrap");
  endtask

  task automatic test_cascade();
    casc_exp_t e, a;
    int ones = 0, tens = 0, hi_wraps = 0;
    async_clear("casc_clear");
    checks++;
    if (lo_count !== '0 || hi_count !== '0) begin
      failures++;
      $display("FAIL casc_start: pair=%0d%0d expected=00", hi_count, lo_count);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      casc_en = 1'b1;
      e.hi_wrap = 1'b0;
      if (ones == M-1) begin
        ones = 0;
        if (tens == M-1) begin tens = 0; e.hi_wrap = 1'b1; end
        else tens = tens + 1;
      end else begin
        ones = ones + 1;
      end
      e.hi = W'(tens); e.lo = W'(ones);
      casc_q.push_back(e);
      @(posedge clk);
      #1;
      if (hi_wrap === 1'b1) hi_wraps++;
      a = casc_q.pop_front();
      checks++;
      if (hi_count !== a.hi || lo_count !== a.lo || hi_wrap !== a.hi_wrap) begin
        failures++;
        $display("FAIL cascade_%0d: pair=%0d%0d hi_wrap=%b expected pair=%0d%0d hi_wrap=%b",
                 i, hi_count, lo_count, hi_wrap, a.hi, a.lo, a.hi_wrap);
      end
      if (i == 98) begin
        checks++;
        if (hi_count !== 4'd9 || lo_count !== 4'd9) begin
          failures++;
          $display("FAIL cascade_99: pair=%0d%0d expected=99", hi_count, lo_count);
        end
      end
    end
    @(negedge clk);
    casc_en = 1'b0;
    checks++;
    if (hi_wraps != 1 || hi_count !== '0 || lo_count !== '0) begin
      failures++;
      $display("FAIL cascade_end: hi_wraps=%0d pair=%0d%0d expected 1 and 00",
               hi_wraps, hi_count, lo_count);
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_preset();
    test_reset_mid();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
